// File: rtl/uart_rx_datapath.sv
// UART receive datapath: oversampling edge/bit counters, 3-point majority sampler,
// LSB-first deserializer and start/parity/stop checkers driven by the RX control FSM.
module uart_rx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_DATA,
  input  logic [5:0]            Prescale,
  input  logic                  parity_type,
  input  logic                  edge_bit_en,
  input  logic                  dat_samp_en,
  input  logic                  deser_en,
  input  logic                  strt_chk_en,
  input  logic                  par_chk_en,
  input  logic                  stp_chk_en,
  output logic [5:0]            edge_count,
  output logic [3:0]            bit_count,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [DATA_WIDTH-1:0] P_DATA
);

  logic [5:0] w_mid;
  logic [5:0] w_last;
  logic       w_at_chk;
  logic       w_at_last;
  logic       w_maj;
  logic       r_s0;
  logic       r_s1;
  logic       r_sampled;

  assign w_mid     = {1'b0, Prescale[5:1]};
  assign w_last    = Prescale - 6'd1;
  assign w_at_chk  = (edge_count == w_mid + 6'd1);
  assign w_at_last = (edge_count == w_last);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & S_DATA) | (r_s1 & S_DATA);

  // Counters restart from 0 whenever the FSM drops edge_bit_en (idle / err_chk).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!edge_bit_en) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (w_at_last) begin
      edge_count <= '0;
      if (bit_count != 4'hF) bit_count <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  // Three samples around mid-bit; a single-cycle spike cannot flip the vote.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_sampled <= 1'b0;
    end else if (dat_samp_en) begin
      if (edge_count == w_mid - 6'd2) r_s0 <= S_DATA;
      if (edge_count == w_mid - 6'd1) r_s1 <= S_DATA;
      if (edge_count == w_mid)        r_sampled <= w_maj;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strt_glitch <= 1'b0;
    end else if (!edge_bit_en) begin
      strt_glitch <= 1'b0;
    end else if (strt_chk_en && w_at_chk) begin
      strt_glitch <= r_sampled;
    end
  end

  // Error flags persist through idle so the FSM can read them; a new start clears them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (strt_chk_en) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else begin
      if (par_chk_en && w_at_chk) par_err <= r_sampled ^ (^P_DATA) ^ parity_type;
      if (stp_chk_en && w_at_chk) stp_err <= ~r_sampled;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA <= '0;
    end else if (deser_en && w_at_last) begin
      P_DATA <= {r_sampled, P_DATA[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: plays the RX FSM, builds frames from a byte plus flags and
// compares against the intended frame contents (majority tolerates one spike per bit).
module tb_uart_rx_datapath;

  logic       CLK = 1'b0;
  logic       RST;
  logic       S_DATA;
  logic [5:0] Prescale;
  logic       parity_type;
  logic       edge_bit_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       strt_glitch, par_err, stp_err;
  logic [7:0] P_DATA;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_d;

  uart_rx_datapath #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .Prescale(Prescale), .parity_type(parity_type),
    .edge_bit_en(edge_bit_en), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .edge_count(edge_count), .bit_count(bit_count), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .P_DATA(P_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle(input int n);
    edge_bit_en = 0; dat_samp_en = 0; deser_en = 0;
    strt_chk_en = 0; par_chk_en = 0; stp_chk_en = 0;
    S_DATA = 1;
    repeat (n) next_cyc();
  endtask

  // Drives one frame as the FSM would; stop_at truncates it after that many cycles.
  task automatic run_frame(input logic [7:0] d, input int p, input bit par_en, input bit ptype,
                           input bit bad_par, input bit bad_stp, input int sp_bit,
                           input int sp_edge, input bit rnd_sp, input int stop_at,
                           input string tag);
    logic bits [0:10];
    int   sp   [0:10];
    int   nb, m, b, e;
    nb = par_en ? 11 : 10;
    m  = p / 2;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (par_en) bits[9] = (^d) ^ ptype ^ bad_par;
    bits[nb-1] = ~bad_stp;
    for (int i = 0; i < 11; i++) begin
      sp[i] = -1;
      if (rnd_sp && $urandom_range(0, 1) == 1) sp[i] = int'($urandom_range(0, p - 1));
    end
    if (sp_bit >= 0) sp[sp_bit] = sp_edge;
    Prescale = 6'(p); parity_type = ptype;
    for (int t = 0; t < nb * p; t++) begin
      if (t == stop_at) return;
      b = t / p; e = t % p;
      S_DATA      = bits[b] ^ (e == sp[b]);
      edge_bit_en = 1; dat_samp_en = 1;
      strt_chk_en = (b == 0);
      deser_en    = (b >= 1 && b <= 8);
      par_chk_en  = par_en && (b == 9);
      stp_chk_en  = (b == nb - 1);
      @(negedge CLK);
      if (e == p - 1) begin
        chk({tag, ".bitcnt"}, 32'(bit_count), 32'(b));
        chk({tag, ".edgecnt"}, 32'(edge_count), 32'(e));
      end
      if (par_en && b == 9 && e == m + 1) chk({tag, ".par_pre"}, 32'(par_err), 0);
      if (par_en && b == 9 && e == m + 2) chk({tag, ".par_t"}, 32'(par_err), 32'(bad_par));
      if (b == nb - 1 && e == m + 1) chk({tag, ".stp_pre"}, 32'(stp_err), 0);
      if (b == nb - 1 && e == m + 2) chk({tag, ".stp_t"}, 32'(stp_err), 32'(bad_stp));
      next_cyc();
    end
    chk({tag, ".pdata"}, 32'(P_DATA), 32'(d));
    chk({tag, ".par_err"}, 32'(par_err), par_en ? 32'(bad_par) : 0);
    chk({tag, ".stp_err"}, 32'(stp_err), 32'(bad_stp));
    chk({tag, ".glitch"}, 32'(strt_glitch), 0);
    last_d = d;
    go_idle(2);
  endtask

  initial begin
    logic [7:0] d;
    int p;
    bit pe, pt, bp, bs;
    RST = 1;
    go_idle(0);
    Prescale = 6'd8; parity_type = 0;
    #2 RST = 0;
    #1;
    chk("rst.edge", 32'(edge_count), 0);
    chk("rst.bit", 32'(bit_count), 0);
    chk("rst.pdata", 32'(P_DATA), 0);
    chk("rst.glitch", 32'(strt_glitch), 0);
    chk("rst.par", 32'(par_err), 0);
    chk("rst.stp", 32'(stp_err), 0);
    #19 RST = 1;
    next_cyc();
    go_idle(2);

    run_frame(8'hA5, 8, 1, 0, 0, 0, -1, 0, 0, -1, "a5");
    run_frame(8'h3C, 16, 1, 1, 1, 0, -1, 0, 0, -1, "badpar");
    run_frame(8'h96, 32, 1, 0, 0, 1, -1, 0, 0, -1, "badstp");
    run_frame(8'h00, 8, 0, 0, 0, 0, -1, 0, 0, -1, "clr");

    // false start: 2-cycle low pulse at idle, FSM aborts after the start check
    Prescale = 6'd8;
    edge_bit_en = 1; dat_samp_en = 1; strt_chk_en = 1;
    for (int t = 0; t <= 6; t++) begin
      S_DATA = (t < 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (t == 5) chk("glitch.pre", 32'(strt_glitch), 0);
      if (t == 6) chk("glitch.set", 32'(strt_glitch), 1);
      next_cyc();
    end
    chk("glitch.pdata", 32'(P_DATA), 32'(last_d));
    go_idle(1);
    chk("glitch.clr", 32'(strt_glitch), 0);
    go_idle(1);

    d = 8'hC3;
    run_frame(d, 16, 1, 0, 0, 0, 3, 7, 0, -1, "spike");
    chk("spike.b2", 32'(P_DATA[2]), 32'(d[2]));

    // bit_count saturation
    Prescale = 6'd8; edge_bit_en = 1;
    repeat (17 * 8 + 3) next_cyc();
    chk("sat.bit", 32'(bit_count), 15);
    go_idle(2);

    // asynchronous reset in the middle of data bit 5
    run_frame(8'hFF, 16, 1, 0, 0, 0, -1, 0, 0, 5 * 16 + 3, "trunc");
    chk("trunc.bit", 32'(bit_count), 5);
    #2 RST = 0;
    #1;
    chk("mrst.edge", 32'(edge_count), 0);
    chk("mrst.bit", 32'(bit_count), 0);
    chk("mrst.pdata", 32'(P_DATA), 0);
    chk("mrst.par", 32'(par_err) | 32'(stp_err) | 32'(strt_glitch), 0);
    go_idle(0);
    #2 RST = 1;
    next_cyc();
    go_idle(1);
    run_frame(8'h5A, 16, 1, 0, 0, 0, -1, 0, 0, -1, "post_rst");

    for (int n = 0; n < 25; n++) begin
      d  = 8'($urandom);
      p  = 8 + 2 * int'($urandom_range(0, 27));
      pe = $urandom_range(0, 3) != 0;
      pt = 1'($urandom);
      bp = $urandom_range(0, 3) == 0;
      bs = $urandom_range(0, 3) == 0;
      run_frame(d, p, pe, pt, bp, bs, -1, 0, 1, -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
